// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: DEPTH x 32-bit words, byte/halfword/word writes,
// programmable wait states and two-cycle ERROR responses for illegal transfers.
module ahb_slave_mem #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      r_state;
    logic        r_hready;
    logic        r_hresp;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_write;
    logic [2:0]  r_size;
    logic [31:0] r_mem [DEPTH];

    logic             w_accept;
    logic             w_misalign;
    logic             w_range;
    logic             w_legal;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused;

    // HREADY doubles as HREADYIN: this slave is the only target on its bus.
    assign w_accept   = HSEL & HTRANS[1] & r_hready;
    assign w_misalign = ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign w_range    = ({2'b00, HADDR[31:2]} >= 32'(DEPTH));
    assign w_legal    = (HSIZE <= 3'd2) && !w_misalign && !w_range;
    assign w_idx      = r_addr[IDX_W+1:2];

    // Bursts arrive as individually addressed beats, so HBURST carries no information here.
    assign w_unused = ^{HBURST, HTRANS[0], r_addr};

    assign HREADY = r_hready;
    assign HRESP  = r_hresp;
    assign HRDATA = (r_state == S_DATA) ? r_mem[w_idx] : 32'h0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
            r_cnt    <= 4'd0;
            r_addr   <= 32'h0;
            r_write  <= 1'b0;
            r_size   <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else begin
            if ((r_state == S_DATA) && r_write) begin
                case (r_size)
                    3'd0:    r_mem[w_idx][{r_addr[1:0], 3'b000} +: 8] <=
                                 HWDATA[{r_addr[1:0], 3'b000} +: 8];
                    3'd1:    r_mem[w_idx][{r_addr[1], 4'b0000} +: 16] <=
                                 HWDATA[{r_addr[1], 4'b0000} +: 16];
                    default: r_mem[w_idx] <= HWDATA;
                endcase
            end

            case (r_state)
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state  <= S_DATA;
                        r_hready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state  <= S_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                // IDLE, DATA and ERR2 all present HREADY=1 and may take a new address phase.
                default: begin
                    if (w_accept) begin
                        r_addr  <= HADDR;
                        r_write <= HWRITE;
                        r_size  <= HSIZE;
                        if (!w_legal) begin
                            r_state  <= S_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            r_state  <= S_DATA;
                            r_hready <= 1'b1;
                            r_hresp  <= 1'b0;
                        end else begin
                            r_state  <= S_WAIT;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b0;
                            r_cnt    <= 4'(WAIT_STATES);
                        end
                    end else begin
                        r_state  <= S_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
